// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states, overflow helper.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_MVN = 3'b011;
  localparam logic [2:0] OP_SHL = 3'b100;
  localparam logic [2:0] OP_SHR = 3'b101;
  localparam logic [2:0] OP_ASR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Signed overflow for ADD/SUB from the sign bits only, so it works for any W.
  function automatic logic v_addsub(input logic is_sub, input logic a_s,
                                    input logic b_s, input logic r_s);
    if (is_sub) v_addsub = (a_s != b_s) && (r_s != a_s);
    else        v_addsub = (a_s == b_s) && (r_s != a_s);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle between the datapath controller and alu_seq.
interface alu_seq_if #(parameter int W = 16);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] Ain;
  logic [W-1:0] Bin;
  logic [2:0]   ALUop;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         N;
  logic         V;
  logic         Z;

  modport master (
    output in_valid, Ain, Bin, ALUop, out_ready,
    input  in_ready, out_valid, out, N, V, Z
  );

  modport slave (
    input  in_valid, Ain, Bin, ALUop, out_ready,
    output in_ready, out_valid, out, N, V, Z
  );

endinterface

// File: rtl/alu_core_w.sv
// Combinational single-cycle ALU: ADD, SUB, AND, MVN with signed overflow.
module alu_core_w
  import alu_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [1:0]   op,
  output logic [W-1:0] result,
  output logic         v
);

  // Select the legacy operation; V is only meaningful for ADD and SUB.
  always_comb begin
    result = '0;
    v      = 1'b0;
    case ({1'b0, op})
      OP_ADD: begin
        result = a + b;
        v      = v_addsub(1'b0, a[W-1], b[W-1], result[W-1]);
      end
      OP_SUB: begin
        result = a - b;
        v      = v_addsub(1'b1, a[W-1], b[W-1], result[W-1]);
      end
      OP_AND:  result = a & b;
      OP_MVN:  result = ~b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/arith ops, iterative shifts and shift-add multiply.
module alu_seq
  import alu_pkg::*;
#(
  parameter int W = 16
) (
  input logic       clk,
  input logic       reset,
  alu_seq_if.slave  bus
);

  localparam int SW = $clog2(W);
  localparam logic [SW:0] CNT_MUL = (SW + 1)'(W);
  localparam logic [SW:0] CNT_ONE = (SW + 1)'(1);

  state_t         state;
  state_t         state_nx;
  logic           accept;
  logic [2:0]     op_q;
  logic [W-1:0]   work;
  logic [W-1:0]   mplier;
  logic [2*W-1:0] mcand;
  logic [2*W-1:0] prod;
  logic [SW:0]    cnt;

  logic [W-1:0]   core_res;
  logic           core_v;
  logic [W-1:0]   sh_step;
  logic [2*W-1:0] prod_step;

  logic           load_en;
  logic [W-1:0]   load_val;
  logic           load_v;

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign accept        = bus.in_valid && (state == S_IDLE);

  alu_core_w #(.W(W)) u_core (
    .a      (bus.Ain),
    .b      (bus.Bin),
    .op     (bus.ALUop[1:0]),
    .result (core_res),
    .v      (core_v)
  );

  // One iteration of the captured shift or multiply, evaluated every EXEC cycle.
  always_comb begin
    sh_step = work;
    case (op_q)
      OP_SHL:  sh_step = work << 1;
      OP_SHR:  sh_step = work >> 1;
      OP_ASR:  sh_step = {work[W-1], work[W-1:1]};
      default: sh_step = work;
    endcase
    prod_step = prod + (mplier[0] ? mcand : '0);
  end

  // Next-state decode and selection of the value loaded into out/flags on entry to DONE.
  always_comb begin
    state_nx = state;
    load_en  = 1'b0;
    load_val = '0;
    load_v   = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (!bus.ALUop[2]) begin
            state_nx = S_DONE;
            load_en  = 1'b1;
            load_val = core_res;
            load_v   = core_v;
          end else if ((bus.ALUop != OP_MUL) && (bus.Bin[SW-1:0] == '0)) begin
            state_nx = S_DONE;
            load_en  = 1'b1;
            load_val = bus.Ain;
          end else begin
            state_nx = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        if (cnt == CNT_ONE) begin
          state_nx = S_DONE;
          load_en  = 1'b1;
          if (op_q == OP_MUL) begin
            load_val = prod_step[W-1:0];
            load_v   = |prod_step[2*W-1:W];
          end else begin
            load_val = sh_step;
          end
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Operand capture on accept, then one shift/multiply step per EXEC cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q   <= OP_ADD;
      work   <= '0;
      mplier <= '0;
      mcand  <= '0;
      prod   <= '0;
      cnt    <= '0;
    end else if (accept) begin
      op_q   <= bus.ALUop;
      work   <= bus.Ain;
      mplier <= bus.Bin;
      mcand  <= {{W{1'b0}}, bus.Ain};
      prod   <= '0;
      cnt    <= (bus.ALUop == OP_MUL) ? CNT_MUL : {1'b0, bus.Bin[SW-1:0]};
    end else if (state == S_EXEC) begin
      work   <= sh_step;
      mplier <= mplier >> 1;
      mcand  <= mcand << 1;
      prod   <= prod_step;
      cnt    <= cnt - CNT_ONE;
    end
  end

  // Result and status registers; they only change when a result lands in DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out <= '0;
      bus.N   <= 1'b0;
      bus.V   <= 1'b0;
      bus.Z   <= 1'b0;
    end else if (load_en) begin
      bus.out <= load_val;
      bus.N   <= load_val[W-1];
      bus.V   <= load_v;
      bus.Z   <= (load_val == '0);
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at W=16.
module tb_alu_seq;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  alu_seq_if #(.W(16)) bus ();

  alu_seq #(.W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, then count cycles until out_valid (bounded); DUT left waiting in DONE.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] op, output int lat);
    if (bus.in_ready !== 1'b1) begin
      $display("[TB] FAIL in_ready before issue: got %b want 1", bus.in_ready);
      bad++;
    end
    total++;
    bus.in_valid = 1'b1;
    bus.Ain      = a;
    bus.Bin      = b;
    bus.ALUop    = op;
    tick();
    bus.in_valid = 1'b0;
    bus.Ain      = ~a;
    bus.Bin      = ~b;
    bus.ALUop    = ~op;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 60) begin
      tick();
      lat++;
    end
    if (bus.out_valid !== 1'b1) begin
      $display("[TB] FAIL out_valid timeout: got %b want 1 within 60 cycles", bus.out_valid);
      bad++;
    end
    total++;
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      $display("[TB] FAIL reset handshake: got %b want 10", {bus.in_ready, bus.out_valid});
      bad++;
    end
    total++;
    if ({bus.out, bus.N, bus.V, bus.Z} !== 19'h0) begin
      $display("[TB] FAIL reset result: got out=%h NVZ=%b%b%b want 0000 000",
               bus.out, bus.N, bus.V, bus.Z);
      bad++;
    end
    total++;
  endtask

  task automatic test_add();
    int lat;
    run_op(16'h7FFF, 16'h0001, OP_ADD, lat);
    if (lat != 1) begin
      $display("[TB] FAIL add latency: got %0d want 1", lat);
      bad++;
    end
    total++;
    if ({bus.out, bus.N, bus.V, bus.Z} !== {16'h8000, 3'b110}) begin
      $display("[TB] FAIL add overflow: got out=%h NVZ=%b%b%b want 8000 110",
               bus.out, bus.N, bus.V, bus.Z);
      bad++;
    end
    total++;
    release_result();
    run_op(16'hFFFF, 16'h0001, OP_ADD, lat);
    if ({bus.out, bus.N, bus.V, bus.Z} !== {16'h0000, 3'b001}) begin
      $display("[TB] FAIL add wrap: got out=%h NVZ=%b%b%b want 0000 001",
               bus.out, bus.N, bus.V, bus.Z);
      bad++;
    end
    total++;
    release_result();
  endtask

  task automatic test_sub_logic();
    int lat;
    run_op(16'h0005, 16'h0005, OP_SUB, lat);
    if ({bus.out, bus.N, bus.V, bus.Z} !== {16'h0000, 3'b001}) begin
      $display("[TB] FAIL sub zero: got out=%h NVZ=%b%b%b want 0000 001",
               bus.out, bus.N, bus.V, bus.Z);
      bad++;
    end
    total++;
    release_result();
    run_op(16'h8000, 16'h0001, OP_SUB, lat);
    if ({bus.out, bus.N, bus.V, bus.Z} !== {16'h7FFF, 3'b010}) begin
      $display("[TB] FAIL sub overflow: got out=%h NVZ=%b%b%b want 7fff 010",
               bus.out, bus.N, bus.V, bus.Z);
      bad++;
    end
    total++;
    release_result();
    run_op(16'hF0F0, 16'h0FF0, OP_AND, lat);
    if ({bus.out, bus.N, bus.V, bus.Z} !== {16'h00F0, 3'b000}) begin
      $display("[TB] FAIL and: got out=%h NVZ=%b%b%b want 00f0 000",
               bus.out, bus.N, bus.V, bus.Z);
      bad++;
    end
    total++;
    release_result();
    run_op(16'h1234, 16'h00FF, OP_MVN, lat);
    if ({bus.out, bus.N, bus.V, bus.Z} !== {16'hFF00, 3'b100}) begin
      $display("[TB] FAIL mvn: got out=%h NVZ=%b%b%b want ff00 100",
               bus.out, bus.N, bus.V, bus.Z);
      bad++;
    end
    total++;
    release_result();
  endtask

  task automatic test_mul();
    int lat;
    run_op(16'h00FF, 16'h0003, OP_MUL, lat);
    if (lat != 17) begin
      $display("[TB] FAIL mul latency: got %0d want 17", lat);
      bad++;
    end
    total++;
    if ({bus.out, bus.N, bus.V, bus.Z} !== {16'h02FD, 3'b000}) begin
      $display("[TB] FAIL mul small: got out=%h NVZ=%b%b%b want 02fd 000",
               bus.out, bus.N, bus.V, bus.Z);
      bad++;
    end
    total++;
    release_result();
    run_op(16'h0100, 16'h0100, OP_MUL, lat);
    if ({bus.out, bus.N, bus.V, bus.Z} !== {16'h0000, 3'b011}) begin
      $display("[TB] FAIL mul overflow: got out=%h NVZ=%b%b%b want 0000 011",
               bus.out, bus.N, bus.V, bus.Z);
      bad++;
    end
    total++;
    release_result();
  endtask

  task automatic test_shift();
    int lat;
    run_op(16'h8000, 16'h0003, OP_ASR, lat);
    if (lat != 4) begin
      $display("[TB] FAIL asr latency: got %0d want 4", lat);
      bad++;
    end
    total++;
    if ({bus.out, bus.N, bus.V, bus.Z} !== {16'hF000, 3'b100}) begin
      $display("[TB] FAIL asr: got out=%h NVZ=%b%b%b want f000 100",
               bus.out, bus.N, bus.V, bus.Z);
      bad++;
    end
    total++;
    release_result();
    run_op(16'h8000, 16'h000F, OP_SHR, lat);
    if ({lat, bus.out} !== {32'd16, 16'h0001}) begin
      $display("[TB] FAIL shr 15: got lat=%0d out=%h want lat=16 out=0001", lat, bus.out);
      bad++;
    end
    total++;
    release_result();
    run_op(16'h1234, 16'h0000, OP_SHL, lat);
    if ({lat, bus.out} !== {32'd1, 16'h1234}) begin
      $display("[TB] FAIL shl 0: got lat=%0d out=%h want lat=1 out=1234", lat, bus.out);
      bad++;
    end
    total++;
    release_result();
    run_op(16'h0001, 16'h0014, OP_SHL, lat);
    if ({lat, bus.out, bus.V} !== {32'd5, 16'h0010, 1'b0}) begin
      $display("[TB] FAIL shl amount field: got lat=%0d out=%h V=%b want lat=5 out=0010 V=0",
               lat, bus.out, bus.V);
      bad++;
    end
    total++;
    release_result();
  endtask

  task automatic test_backpressure();
    int lat;
    int unstable;
    run_op(16'h1111, 16'h2222, OP_ADD, lat);
    unstable = 0;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = i[0];
      bus.Ain      = 16'hA5A5 ^ 16'(i);
      bus.ALUop    = OP_SUB;
      tick();
      if ({bus.out_valid, bus.in_ready, bus.out, bus.N, bus.V, bus.Z} !== {2'b10, 16'h3333, 3'b000})
        unstable++;
    end
    if (unstable != 0) begin
      $display("[TB] FAIL backpressure hold: got %0d unstable cycles want 0", unstable);
      bad++;
    end
    total++;
    bus.in_valid = 1'b0;
    release_result();
    if ({bus.in_ready, bus.out_valid, bus.out} !== {2'b10, 16'h3333}) begin
      $display("[TB] FAIL release to idle: got rdy=%b vld=%b out=%h want 1 0 3333",
               bus.in_ready, bus.out_valid, bus.out);
      bad++;
    end
    total++;
    run_op(16'h0001, 16'h0001, OP_ADD, lat);
    if ({lat, bus.out} !== {32'd1, 16'h0002}) begin
      $display("[TB] FAIL back_to_back: got lat=%0d out=%h want lat=1 out=0002", lat, bus.out);
      bad++;
    end
    total++;
    release_result();
  endtask

  task automatic test_reset_mid_mul();
    int lat;
    int stray;
    bus.in_valid = 1'b1;
    bus.Ain      = 16'h00FF;
    bus.Bin      = 16'h0003;
    bus.ALUop    = OP_MUL;
    tick();
    bus.in_valid = 1'b0;
    stray = 0;
    for (int i = 1; i < 8; i++) begin
      if (bus.out_valid !== 1'b0) stray++;
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    if ({bus.in_ready, bus.out_valid, bus.out, bus.N, bus.V, bus.Z} !== {2'b10, 19'h0}) begin
      $display("[TB] FAIL mid-mul reset: got rdy=%b vld=%b out=%h NVZ=%b%b%b want 1 0 0000 000",
               bus.in_ready, bus.out_valid, bus.out, bus.N, bus.V, bus.Z);
      bad++;
    end
    total++;
    for (int i = 0; i < 20; i++) begin
      if (bus.out_valid !== 1'b0) stray++;
      tick();
    end
    if (stray != 0) begin
      $display("[TB] FAIL aborted mul stray valid: got %0d cycles want 0", stray);
      bad++;
    end
    total++;
    run_op(16'h0002, 16'h0003, OP_ADD, lat);
    if ({bus.out, bus.N, bus.V, bus.Z} !== {16'h0005, 3'b000}) begin
      $display("[TB] FAIL add after reset: got out=%h NVZ=%b%b%b want 0005 000",
               bus.out, bus.N, bus.V, bus.Z);
      bad++;
    end
    total++;
    release_result();
  endtask

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.Ain       = '0;
    bus.Bin       = '0;
    bus.ALUop     = OP_ADD;
    bus.out_ready = 1'b0;
    #1;
    test_reset();
    test_add();
    test_sub_logic();
    test_mul();
    test_shift();
    test_backpressure();
    test_reset_mid_mul();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, handshaked successor to the datapath ALU. It keeps the four legacy operations (ADD, SUB, AND, MVN) with identical 2-bit encodings when ALUop[2]=0, and adds iterative shifts and an iterative multiply. Unlike the legacy block, it registers its result and N/V/Z status, and computes V correctly for both ADD and SUB at full width. It sits between the register-file operand latches (A/B) and the writeback/status register in the CPU datapath. The controller FSM drives it through a valid/ready handshake.

Parameters:
W, 16, datapath width in bits; power of two, minimum 4.
SW, $clog2(W), shift-amount width (derived; not overridden).

Ports:
clk  input  1  rising-edge clock.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  operands and op valid.
in_ready  output  1  block can accept; high only in IDLE.
Ain  input  W  operand A.
Bin  input  W  operand B; Bin[SW-1:0] is the shift amount for shift ops.
ALUop  input  3  operation code.
out_valid  output  1  result and flags valid.
out_ready  input  1  consumer accepts result.
out  output  W  registered result.
N  output  1  registered: out[W-1].
V  output  1  registered overflow.
Z  output  1  registered: out==0.

Behaviour:
- Reset, with the same semantics in any state including mid-EXEC:
  - state=IDLE; out=0; N=V=Z=0; out_valid=0; the counter is cleared.
  - An aborted operation never produces out_valid.
- Opcodes:
  - 000 ADD: Ain+Bin.
  - 001 SUB: Ain-Bin.
  - 010 AND: Ain&Bin.
  - 011 MVN: ~Bin.
  - 100 SHL: logical left shift.
  - 101 SHR: logical right shift.
  - 110 ASR: arithmetic right shift.
  - 111 MUL: low W bits of unsigned Ain*Bin.
- Accept: a transfer occurs when in_valid && in_ready. Ain, Bin and ALUop are captured in that cycle; later input changes are ignored.
- States:
  - IDLE: in_ready=1. On accept with op 000-011, or a shift with amount 0, go to DONE next cycle with the result loaded. Otherwise go to EXEC.
  - EXEC: in_ready=0, out_valid=0.
    - Shift: one bit per cycle for k=Bin[SW-1:0] cycles.
    - MUL: shift-add, one multiplier bit per cycle, exactly W cycles.
    - Then go to DONE, loading out and flags on the EXEC→DONE edge.
  - DONE: out_valid=1. out and N/V/Z are held stable. On out_ready go to IDLE.
- Latency, counted from the accept edge to the first cycle with out_valid=1:
  - Single-cycle ops and shift-by-0: 1 cycle.
  - Shift by k: k+1 cycles.
  - MUL: W+1 cycles.
- Throughput: there is no accept in the same cycle as DONE→IDLE. The minimum issue interval is 2 cycles.
- V rules (sign bit S=W-1):
  - ADD: V=(Ain[S]==Bin[S]) && (out[S]!=Ain[S]).
  - SUB: V=(Ain[S]!=Bin[S]) && (out[S]!=Ain[S]).
  - MUL: V=1 iff the upper W bits of the full 2W-bit product are nonzero.
  - AND, MVN, shifts: V=0.
- Arithmetic wraps modulo 2^W. Carry is not exported.
- N and Z are always derived from the final registered out.
- Flags and out change only on the edge entering DONE or on reset. They persist through IDLE until the next result.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams OP_ADD..OP_MUL (3-bit);
  - state encoding S_IDLE/S_EXEC/S_DONE;
  - the V-flag function for ADD and SUB, parametrised by W.
- One sub-module, alu_core_w #(W): purely combinational ADD/SUB/AND/MVN with V. alu_seq instantiates it for single-cycle ops; the shift/multiply iteration and the FSM stay in alu_seq.

Test Plan:
1. W=16, ADD 0x7FFF+0x0001 → out=0x8000, N=1, V=1, Z=0; out_valid 1 cycle after accept. ADD 0xFFFF+0x0001 → 0x0000, Z=1, V=0.
2. SUB 0x0005-0x0005 → 0x0000, Z=1, V=0. SUB 0x8000-0x0001 → 0x7FFF, N=0, V=1. AND 0xF0F0&0x0FF0 → 0x00F0. MVN Bin=0x00FF → 0xFF00, N=1.
3. MUL 0x00FF*0x0003 → 0x02FD, V=0, out_valid exactly 17 cycles after accept. MUL 0x0100*0x0100 → 0x0000, V=1, Z=1.
4. ASR Ain=0x8000, Bin=3 → 0xF000, N=1, out_valid 4 cycles after accept. SHR 0x8000 by 15 → 0x0001. SHL 0x1234 by 0 → 0x1234 with 1-cycle latency.
5. Backpressure: hold out_ready=0 for 5 cycles in DONE → out, N, V, Z and out_valid stable, in_ready=0, toggling in_valid/Ain ignored. Raising out_ready → IDLE next cycle; a new accept is possible the cycle after.
6. Assert reset in the 8th EXEC cycle of a MUL → next cycle IDLE, out_valid=0, out=0, flags 0, with no stray out_valid. A following ADD 0x0002+0x0003 yields 0x0005.
